sound_arbiter: RTL and testbench
================================

# sound_arbiter

Shares the single piezo sound engine between four event sources such as game events, UI beeps and alarms. Pending requests are latched and granted round-robin. For each grant the block issues a one-cycle `SND_REQ` start pulse with a 2-bit tone select, waits for the engine's finish handshake, then enforces a silent gap before the next grant. It sits between the game/control logic and the piezo engine.

## Interface
Parameters:
- `GAP_CYCLES`, default 2_500_000: silent cycles after each sound; 0 means no gap.
- `TIMEOUT_CYCLES`, default 2_000_000: watchdog limit per sound; used only with the macro enabled.

Ports (one clock; reset is synchronous and active-high):
- `USER_CLK` input 1: system clock; all logic on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `REQ` input 4: request levels; sampled every cycle.
- `SND_FINISH` input 1: engine finish flag; 1 means idle/done.
- `SND_REQ` output 1: one-cycle start pulse to the engine.
- `SND_SEL` output 2: index of the granted requester; held stable while granted.
- `GRANT` output 4: one-hot current owner; 0 when no sound is active.
- `BUSY` output 1: 1 in every state except IDLE.
- `DONE` output 4: one-cycle pulse on the owner's bit when its sound completes.
- `ERR` output 1: one-cycle watchdog pulse; constant 0 without the macro.

## Operation
Pending latch:
- `pending[i]` is set on any cycle where `REQ[i]` is 1.
- It is cleared on the edge that grants channel i.
- If set and clear coincide, set wins, so a re-request during the grant edge replays later.
- Repeated requests while pending merge into one.

Arbitration:
- 2-bit pointer `last`, reset value 3.
- The search starts at `last+1` and wraps modulo 4; the first pending channel wins.
- `last` is loaded with the winner on grant.

States:
- IDLE: if `pending` is nonzero, grant the winner. On that edge: `SND_REQ`<=1, `SND_SEL`<=idx, `GRANT`<=onehot, clear the counter, go to ACK.
- ACK: `SND_REQ`<=0. Wait for `SND_FINISH`==0, the engine's acknowledge, then go to PLAY. `SND_FINISH`==1 here is ignored as stale.
- PLAY: wait for `SND_FINISH`==1. On that edge: `DONE[idx]`<=1 for one cycle, `GRANT`<=0, clear the counter, go to GAP.
  - If `GAP_CYCLES`==0, go to IDLE instead.
- GAP: the counter increments each cycle. When counter == `GAP_CYCLES`-1, go to IDLE.
  - Requests still latch during ACK, PLAY and GAP.

Counter rules:
- The counter is 32-bit unsigned and saturates rather than wraps.
- It is cleared on every state entry.

Reset:
- `RESET` in any state forces IDLE and clears `pending`, `GRANT`, `SND_REQ`, `DONE` and `ERR`.
- Sets `last`=3 and `SND_SEL`=0.
- An in-flight engine sound is abandoned: no `DONE`, no `ERR`.

## Timing
- Reset values: `SND_REQ`=0, `SND_SEL`=0, `GRANT`=0, `BUSY`=0, `DONE`=0, `ERR`=0.
- `REQ[i]` high in cycle t: `pending[i]`=1 in t+1; `SND_REQ`, `GRANT` and `BUSY` are high in t+2 (two-cycle latency from idle).
- `SND_REQ` is exactly one cycle wide; `SND_SEL` is stable from the `SND_REQ` cycle until `GRANT` drops.
- `SND_FINISH` rising in PLAY cycle u: `DONE` pulse and `GRANT`=0 in u+1.
- Next `SND_REQ` comes no earlier than u+1+`GAP_CYCLES`+1.
- Simultaneous requests in IDLE: grant order follows the round-robin pointer, one per sound.
- `REQ` held continuously on all four channels: grant order 0,1,2,3,0,…

## Configuration
Macro `SOUND_ARB_TIMEOUT_EN`:
- Defined: the counter also runs in ACK and PLAY. When it reaches `TIMEOUT_CYCLES`:
  - `ERR`<=1 for one cycle and `GRANT`<=0; no `DONE` pulse.
  - Go to GAP with the counter cleared.
  - The channel is not re-pended.
- Undefined: ACK and PLAY wait indefinitely. `ERR` is tied to 0 and the watchdog compare logic is absent.

## Test plan
Bench parameters: `GAP_CYCLES`=4, `TIMEOUT_CYCLES`=20; the engine model drops `SND_FINISH` one cycle after `SND_REQ` and raises it 10 cycles later.
- Single request: `REQ`=4'b0010 for 1 cycle at t=0 → `SND_REQ` and `GRANT`=0010 at t=2, `SND_SEL`=1, `DONE`=0010 pulse 12 cycles later, `BUSY` low 4 cycles after that.
- All channels: `REQ`=4'b1111 held from reset → grants 0,1,2,3,0 in order, each separated by a 4-cycle gap; `SND_REQ` is never wider than 1 cycle.
- Re-request: `REQ[2]` pulsed during its own PLAY → one additional grant to channel 2 after GAP; multiple pulses still give only one replay.
- Reset mid-PLAY: assert `RESET` for 1 cycle → all outputs 0 next cycle, `pending` empty, no `DONE`; a later `REQ[0]` is granted to channel 0.
- Stale finish: `SND_FINISH` held at 1 for 3 cycles after `SND_REQ` before dropping → block stays in ACK and `DONE` fires only after the genuine rise.
- With `SOUND_ARB_TIMEOUT_EN`: the engine never drops `SND_FINISH` → `ERR` pulses 20 cycles after entering ACK, `GRANT`=0, no `DONE`, and the next pending channel is granted after the gap. Without the macro, `ERR` stays 0 and `BUSY` stays 1.

Source files
------------

// File: rtl/sound_arbiter_if.sv
// Request, engine handshake and status bundle around the piezo sound arbiter.
// master = arbiter side, slave = event sources plus sound engine.
interface sound_arbiter_if;
  logic [3:0] REQ;
  logic       SND_FINISH;
  logic       SND_REQ;
  logic [1:0] SND_SEL;
  logic [3:0] GRANT;
  logic       BUSY;
  logic [3:0] DONE;
  logic       ERR;

  modport master (
    input  REQ, SND_FINISH,
    output SND_REQ, SND_SEL, GRANT, BUSY, DONE, ERR
  );

  modport slave (
    output REQ, SND_FINISH,
    input  SND_REQ, SND_SEL, GRANT, BUSY, DONE, ERR
  );
endinterface

// File: rtl/sound_arbiter.sv
// Round-robin arbiter sharing one piezo engine between four event sources.
// Optional per-state watchdog enabled by defining SOUND_ARB_TIMEOUT_EN.
module sound_arbiter #(
  parameter int unsigned GAP_CYCLES     = 2_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic            USER_CLK,
  input  logic            RESET,
  sound_arbiter_if.master bus
);
  localparam int unsigned CNT_W    = 32;
  localparam logic [CNT_W-1:0] GAP_LAST = 32'(GAP_CYCLES) - 32'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_PLAY, ST_GAP} state_t;

  localparam state_t POST_SOUND = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_pending, w_pend_nxt, w_pend_clr;
  logic [1:0]       r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_snd_req, w_snd_req_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [3:0]       r_grant, w_grant_nxt;
  logic             r_busy, w_busy_nxt;
  logic [3:0]       r_done, w_done_nxt;
  logic             w_win_valid;
  logic [1:0]       w_win_idx;
  logic             w_wd_fire;
  logic             w_cnt_run;

  // First pending channel searching upward from last+1, wrapping mod 4
  always_comb begin : p_rr_pick
    w_win_valid = 1'b0;
    w_win_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_win_valid && r_pending[2'(r_last + 2'(k))]) begin
        w_win_valid = 1'b1;
        w_win_idx   = 2'(r_last + 2'(k));
      end
    end
  end

`ifdef SOUND_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
  logic r_err;

  // Stale-high finish in ACK or missing finish in PLAY both count toward the limit
  assign w_wd_fire = (r_cnt == TIMEOUT_LAST) &&
                     (((r_state == ST_ACK)  &&  bus.SND_FINISH) ||
                      ((r_state == ST_PLAY) && !bus.SND_FINISH));
  assign w_cnt_run = (r_state != ST_IDLE);

  always_ff @(posedge USER_CLK) begin : p_err_reg
    if (RESET) r_err <= 1'b0;
    else       r_err <= w_wd_fire;
  end
  assign bus.ERR = r_err;
`else
  assign w_wd_fire = 1'b0;
  assign w_cnt_run = (r_state == ST_GAP);
  assign bus.ERR   = 1'b0;
  // Watchdog absent; parameter kept so both builds share one instance signature
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_win_valid) w_state_nxt = ST_ACK;
      ST_ACK: begin
        if (!bus.SND_FINISH)  w_state_nxt = ST_PLAY;
        else if (w_wd_fire)   w_state_nxt = POST_SOUND;
      end
      ST_PLAY: begin
        if (bus.SND_FINISH)   w_state_nxt = POST_SOUND;
        else if (w_wd_fire)   w_state_nxt = POST_SOUND;
      end
      ST_GAP:  if (r_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : p_outputs
    w_snd_req_nxt = 1'b0;
    w_done_nxt    = 4'b0000;
    w_sel_nxt     = r_sel;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_pend_clr    = 4'b0000;
    if ((r_state == ST_IDLE) && w_win_valid) begin
      w_snd_req_nxt = 1'b1;
      w_sel_nxt     = w_win_idx;
      w_grant_nxt   = 4'b0001 << w_win_idx;
      w_last_nxt    = w_win_idx;
      w_pend_clr    = 4'b0001 << w_win_idx;
    end
    if ((r_state == ST_PLAY) && bus.SND_FINISH) begin
      w_done_nxt  = r_grant;
      w_grant_nxt = 4'b0000;
    end
    if (w_wd_fire) w_grant_nxt = 4'b0000;
    // Set wins over the grant-edge clear so a re-request replays later
    w_pend_nxt = (r_pending & ~w_pend_clr) | bus.REQ;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    if (w_state_nxt != r_state)                 w_cnt_nxt = '0;
    else if (w_cnt_run && (r_cnt != '1))        w_cnt_nxt = r_cnt + 32'd1;
    else                                        w_cnt_nxt = r_cnt;
  end

  always_ff @(posedge USER_CLK) begin : p_state_reg
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_pending <= 4'b0000;
      r_last    <= 2'd3;
      r_cnt     <= '0;
      r_snd_req <= 1'b0;
      r_sel     <= 2'd0;
      r_grant   <= 4'b0000;
      r_busy    <= 1'b0;
      r_done    <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_snd_req <= w_snd_req_nxt;
      r_sel     <= w_sel_nxt;
      r_grant   <= w_grant_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.SND_REQ = r_snd_req;
  assign bus.SND_SEL = r_sel;
  assign bus.GRANT   = r_grant;
  assign bus.BUSY    = r_busy;
  assign bus.DONE    = r_done;
endmodule

// File: tb/tb_sound_arbiter.sv
// Randomized and directed bench for sound_arbiter against a transaction-level model
// with a simple piezo engine responder.
`timescale 1ns/1ps
module tb_sound_arbiter;
  localparam int unsigned GAP      = 4;
  localparam int unsigned TMO      = 20;
  localparam int          PLAY_LEN = 10;

  logic clk = 1'b0;
  logic rst;
  sound_arbiter_if bus ();

  sound_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .USER_CLK(clk),
    .RESET   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: pending set, pointer, current owner and remaining gap
  logic [3:0] m_pend;
  logic [1:0] m_last;
  int         m_owner;
  bit         m_acked;
  int         m_wait;
  int         m_gap_left;
  logic       e_snd_req, e_busy, e_err;
  logic [1:0] e_sel;
  logic [3:0] e_grant, e_done;
  bit         e_valid = 1'b0;

  // Engine responder and observation log
  int eng_drop = 0, eng_rise = 0, eng_stale = 0;
  bit eng_never = 1'b0;
  int grant_log[$];
  int req_cyc_q[$];
  int done_cyc_q[$];
  int last_req_cyc = 0, last_done_cyc = 0, idle_cyc = 0;
  int n_err_seen = 0;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] p, input logic [1:0] last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (int'(last) + k) % 4;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_end_sound();
    e_grant    = 4'b0000;
    m_owner    = -1;
    m_gap_left = int'(GAP);
  endtask

  task automatic model_timeout_tick();
`ifdef SOUND_ARB_TIMEOUT_EN
    if (m_wait == int'(TMO) - 1) begin
      e_err = 1'b1;
      model_end_sound();
    end else begin
      m_wait++;
    end
`endif
  endtask

  // Consumes one cycle of inputs, produces expected outputs for the next cycle
  task automatic model_step(input logic [3:0] req, input logic fin, input logic r);
    int w;
    e_snd_req = 1'b0;
    e_done    = 4'b0000;
    e_err     = 1'b0;
    if (r) begin
      m_pend = 4'b0000; m_last = 2'd3; m_owner = -1; m_gap_left = 0;
      e_sel = 2'd0; e_grant = 4'b0000; e_busy = 1'b0; e_valid = 1'b1;
      return;
    end
    if (m_owner < 0 && m_gap_left == 0) begin
      w = pick(m_pend, m_last);
      if (w >= 0) begin
        m_pend[w] = 1'b0; m_last = 2'(w); m_owner = w; m_acked = 1'b0; m_wait = 0;
        e_snd_req = 1'b1; e_sel = 2'(w); e_grant = 4'(1 << w);
      end
    end else if (m_owner >= 0) begin
      if (!m_acked) begin
        if (!fin) begin m_acked = 1'b1; m_wait = 0; end
        else model_timeout_tick();
      end else if (fin) begin
        e_done = 4'(1 << m_owner);
        model_end_sound();
      end else begin
        model_timeout_tick();
      end
    end else begin
      m_gap_left--;
    end
    m_pend |= req;
    e_busy = (m_owner >= 0) || (m_gap_left > 0);
  endtask

  task automatic tick(input logic [3:0] req, input logic r);
    logic fin;
    if (e_valid) begin
      check("snd_req", 32'(bus.SND_REQ), 32'(e_snd_req));
      check("snd_sel", 32'(bus.SND_SEL), 32'(e_sel));
      check("grant",   32'(bus.GRANT),   32'(e_grant));
      check("busy",    32'(bus.BUSY),    32'(e_busy));
      check("done",    32'(bus.DONE),    32'(e_done));
      check("err",     32'(bus.ERR),     32'(e_err));
    end
    if (bus.SND_REQ === 1'b1) begin
      eng_drop = cyc + 1 + eng_stale;
      eng_rise = eng_drop + PLAY_LEN;
      last_req_cyc = cyc;
      grant_log.push_back(int'(bus.SND_SEL));
      req_cyc_q.push_back(cyc);
    end
    if (bus.DONE != 4'b0000) begin
      last_done_cyc = cyc;
      done_cyc_q.push_back(cyc);
    end
    if (bus.ERR === 1'b1) n_err_seen++;
    if (prev_busy && !bus.BUSY) idle_cyc = cyc;
    prev_busy = bus.BUSY;
    fin = eng_never ? 1'b1 : !((cyc >= eng_drop) && (cyc < eng_rise));
    bus.REQ        = req;
    bus.SND_FINISH = fin;
    rst            = r;
    model_step(req, fin, r);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(4'b0000, 1'b0);
  endtask

  task automatic do_reset();
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b0);
    grant_log.delete(); req_cyc_q.delete(); done_cyc_q.delete();
  endtask

  initial begin
    int c0, n2;
    bus.REQ = 4'b0000; bus.SND_FINISH = 1'b1; rst = 1'b1;
    @(negedge clk);
    tick(4'b0000, 1'b1);
    tick(4'b0000, 1'b1);
    run(3);

    // Single request: latency to grant, done and idle
    c0 = cyc;
    tick(4'b0010, 1'b0);
    run(25);
    check("lat_req",  32'(last_req_cyc - c0), 32'd2);
    check("lat_done", 32'(last_done_cyc - last_req_cyc), 32'd12);
    check("lat_idle", 32'(idle_cyc - last_done_cyc), 32'(GAP));
    check("sel_one",  32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);

    // All channels held: order 0,1,2,3,0 with minimum gap
    do_reset();
    for (int i = 0; i < 85; i++) tick(4'b1111, 1'b0);
    check("n_grants", 32'(grant_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) check("rr_order", 32'(grant_log[i]), 32'(i % 4));
    for (int i = 1; i < 5 && i < req_cyc_q.size() && i <= done_cyc_q.size(); i++)
      check("gap_len", 32'(req_cyc_q[i] - done_cyc_q[i-1]), 32'(GAP + 1));
    run(40);

    // Re-request of channel 2 during its own PLAY replays exactly once
    do_reset();
    tick(4'b0100, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (grant_log.size() == 1 && m_owner == 2 && m_acked && (i % 3 == 0 || $urandom_range(0, 1) == 1))
        tick(4'b0100, 1'b0);
      else
        tick(4'b0000, 1'b0);
    end
    n2 = 0;
    foreach (grant_log[i]) if (grant_log[i] == 2) n2++;
    check("replay_cnt", 32'(n2), 32'd2);

    // Reset in the middle of PLAY, then a fresh request on channel 0
    do_reset();
    tick(4'b0010, 1'b0);
    for (int i = 0; i < 20 && !(m_owner >= 0 && m_acked); i++) tick(4'b0000, 1'b0);
    run(3);
    tick(4'b0000, 1'b1);
    run(15);
    check("no_done_after_rst", 32'(done_cyc_q.size()), 32'd0);
    tick(4'b0001, 1'b0);
    run(25);
    check("post_rst_grant", 32'(grant_log.size() > 0 ? grant_log[grant_log.size()-1] : -1), 32'd0);

    // Stale finish for three cycles before the genuine acknowledge
    do_reset();
    eng_stale = 3;
    tick(4'b1000, 1'b0);
    run(35);
    check("stale_done", 32'(last_done_cyc - last_req_cyc), 32'(1 + 3 + PLAY_LEN + 1));
    eng_stale = 0;

    // Engine never acknowledges
    do_reset();
    eng_never = 1'b1;
    n_err_seen = 0;
    tick(4'b0011, 1'b0);
    run(40);
`ifdef SOUND_ARB_TIMEOUT_EN
    check("wd_err_cnt", 32'(n_err_seen), 32'd1);
    check("wd_next",    32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd1);
`else
    check("wd_err_cnt", 32'(n_err_seen), 32'd0);
    check("wd_busy",    32'(bus.BUSY), 32'd1);
`endif
    check("wd_no_done", 32'(done_cyc_q.size()), 32'd0);
    eng_never = 1'b0;
    do_reset();

    // Random traffic with varying stale delays and rare resets
    for (int i = 0; i < 700; i++) begin
      if (!bus.BUSY) eng_stale = $urandom_range(0, 3);
      tick(($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000, $urandom_range(0, 199) == 0);
    end
    run(40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
